// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand issue stage directly upstream of the ALU. Decoded instructions
//   arrive over a valid/ready handshake. Each source is read from a 32-entry
//   register file, with a bypass path from the write-back port. A busy
//   scoreboard stalls RAW and WAW hazards. Operands, the op select and the
//   destination tag are held in a registered output slot for the ALU.
//
// Ports
//   clk, rst_n                        clock (rising edge), async active-low reset
//   dec_valid / dec_ready             decode handshake; dec_ready is independent of dec_valid
//   dec_rs1, dec_rs2, dec_rd, dec_we  source/destination indices, write enable
//   dec_imm, dec_use_imm              immediate; replaces rs2 as operand B when set
//   dec_alu_sel                       op code, passed through to alu_sel
//   ex_valid / ex_ready               execute handshake for the registered slot
//   alu_a, alu_b, alu_sel             registered operands and op
//   ex_rd, ex_we                      registered destination tag
//   wb_valid, wb_rd, wb_data          write-back port (never stalls)
//   busy                              scoreboard bits (debug)

module alu_operand_stage #(
   parameter int  XLEN = 32,
   parameter int  NREG = 32,
   localparam int RAW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [RAW-1:0]  dec_rs1,
   input  logic [RAW-1:0]  dec_rs2,
   input  logic [RAW-1:0]  dec_rd,
   input  logic            dec_we,
   input  logic [XLEN-1:0] dec_imm,
   input  logic            dec_use_imm,
   input  logic [2:0]      dec_alu_sel,

   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_sel,
   output logic [RAW-1:0]  ex_rd,
   output logic            ex_we,

   input  logic            wb_valid,
   input  logic [RAW-1:0]  wb_rd,
   input  logic [XLEN-1:0] wb_data,

   output logic [NREG-1:0] busy
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] busy_q, busy_d;

   logic            ex_valid_q, ex_valid_d;
   logic [XLEN-1:0] alu_a_q, alu_a_d;
   logic [XLEN-1:0] alu_b_q, alu_b_d;
   logic [2:0]      alu_sel_q, alu_sel_d;
   logic [RAW-1:0]  ex_rd_q, ex_rd_d;
   logic            ex_we_q, ex_we_d;

   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [NREG-1:0] clr_vec, pend_vec;
   logic            hazard, issue, wb_wr;

   assign wb_wr = wb_valid && (wb_rd != '0);

   // Source read: x0 is hard zero, and an in-flight write-back wins over the array.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (dec_rs1 != '0)
         rs1_val = (wb_valid && wb_rd == dec_rs1) ? wb_data : regs_q[dec_rs1];
      if (dec_rs2 != '0)
         rs2_val = (wb_valid && wb_rd == dec_rs2) ? wb_data : regs_q[dec_rs2];
   end

   // A register is pending only if busy and not being cleared this very cycle.
   always_comb begin
      clr_vec = '0;
      for (int r = 0; r < NREG; r++)
         clr_vec[r] = wb_valid && (wb_rd == RAW'(r));
      pend_vec    = busy_q & ~clr_vec;
      pend_vec[0] = 1'b0;
   end

   assign hazard = pend_vec[dec_rs1]
                 | (!dec_use_imm && pend_vec[dec_rs2])
                 | (dec_we && pend_vec[dec_rd]);

   assign dec_ready = (!ex_valid_q || ex_ready) && !hazard;
   assign issue     = dec_valid && dec_ready;

   always_comb begin
      ex_valid_d = ex_valid_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      ex_rd_d    = ex_rd_q;
      ex_we_d    = ex_we_q;
      busy_d     = busy_q;

      if (issue) begin
         ex_valid_d = 1'b1;
         alu_a_d    = rs1_val;
         alu_b_d    = dec_use_imm ? dec_imm : rs2_val;
         alu_sel_d  = dec_alu_sel;
         ex_rd_d    = dec_rd;
         ex_we_d    = dec_we && (dec_rd != '0);
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end

      // Clear first, then set: a WAW issue racing its own clear stays busy.
      if (wb_wr)
         busy_d[wb_rd] = 1'b0;
      if (issue && dec_we && (dec_rd != '0))
         busy_d[dec_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++)
            regs_q[r] <= '0;
      end else if (wb_wr) begin
         regs_q[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         ex_valid_q <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         ex_rd_q    <= '0;
         ex_we_q    <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         ex_valid_q <= ex_valid_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         ex_rd_q    <= ex_rd_d;
         ex_we_q    <= ex_we_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_sel  = alu_sel_q;
   assign ex_rd    = ex_rd_q;
   assign ex_we    = ex_we_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        dec_valid;
   logic        dec_ready;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_we;
   logic [31:0] dec_imm;
   logic        dec_use_imm;
   logic [2:0]  dec_alu_sel;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_sel;
   logic [4:0]  ex_rd;
   logic        ex_we;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] busy;

   int checks = 0;
   int errors = 0;

   alu_operand_stage #(.XLEN(32), .NREG(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .dec_rs1    (dec_rs1),
      .dec_rs2    (dec_rs2),
      .dec_rd     (dec_rd),
      .dec_we     (dec_we),
      .dec_imm    (dec_imm),
      .dec_use_imm(dec_use_imm),
      .dec_alu_sel(dec_alu_sel),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .ex_rd      (ex_rd),
      .ex_we      (ex_we),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dv, rs1, rs2, rd, we, imm, ui, sel, exr;
      logic [31:0] wbv, wbrd, wbd;
      logic [31:0] e_rdy, e_exv, e_a, e_b, e_sel, e_rd, e_we, e_busy;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      dec_valid   = v.dv[0];
      dec_rs1     = v.rs1[4:0];
      dec_rs2     = v.rs2[4:0];
      dec_rd      = v.rd[4:0];
      dec_we      = v.we[0];
      dec_imm     = v.imm;
      dec_use_imm = v.ui[0];
      dec_alu_sel = v.sel[2:0];
      ex_ready    = v.exr[0];
      wb_valid    = v.wbv[0];
      wb_rd       = v.wbrd[4:0];
      wb_data     = v.wbd;
   endtask

   task automatic check_ex(input int idx, input vec_t v);
      check("ex_valid", idx, 32'(ex_valid), v.e_exv);
      check("alu_a",    idx, alu_a,         v.e_a);
      check("alu_b",    idx, alu_b,         v.e_b);
      check("alu_sel",  idx, 32'(alu_sel),  v.e_sel);
      check("ex_rd",    idx, 32'(ex_rd),    v.e_rd);
      check("ex_we",    idx, 32'(ex_we),    v.e_we);
      check("busy",     idx, busy,          v.e_busy);
   endtask

   initial begin
      vec_t idle;
      //            dv rs1 rs2 rd we imm       ui sel exr  wbv wbrd wbd          rdy exv a          b          sel rd we busy
      vecs[0]  = '{0, 0, 0, 0, 0, 0,        0, 0, 1,   1, 5, 32'h1234,     1, 0, 0,         0,         0, 0, 0, 32'h0};
      vecs[1]  = '{1, 5, 0, 6, 1, 0,        0, 0, 1,   0, 0, 0,            1, 1, 32'h1234,  0,         0, 6, 1, 32'h40};
      vecs[2]  = '{1, 5, 0, 3, 1, 32'h10,   1, 1, 1,   0, 0, 0,            1, 1, 32'h1234,  32'h10,    1, 3, 1, 32'h48};
      vecs[3]  = '{1, 3, 0, 8, 1, 0,        0, 5, 1,   0, 0, 0,            0, 0, 32'h1234,  32'h10,    1, 3, 1, 32'h48};
      vecs[4]  = '{1, 3, 0, 8, 1, 0,        0, 5, 1,   1, 3, 32'hABCD,     1, 1, 32'hABCD,  0,         5, 8, 1, 32'h140};
      vecs[5]  = '{1, 5, 5, 9, 1, 0,        0, 6, 0,   0, 0, 0,            0, 1, 32'hABCD,  0,         5, 8, 1, 32'h140};
      vecs[6]  = vecs[5];
      vecs[7]  = vecs[5];
      vecs[8]  = '{1, 5, 5, 9, 1, 0,        0, 6, 1,   0, 0, 0,            1, 1, 32'h1234,  32'h1234,  6, 9, 1, 32'h340};
      vecs[9]  = '{1, 0, 0, 0, 1, 0,        0, 2, 1,   1, 0, 32'hFFFF,     1, 1, 0,         0,         2, 0, 0, 32'h340};
      vecs[10] = '{1, 0, 0, 0, 0, 32'h7,    1, 7, 1,   0, 0, 0,            1, 1, 0,         32'h7,     7, 0, 0, 32'h340};
      vecs[11] = '{1, 0, 0, 7, 1, 32'h1,    1, 0, 1,   0, 0, 0,            1, 1, 0,         32'h1,     0, 7, 1, 32'h3C0};
      vecs[12] = '{1, 0, 0, 7, 1, 32'h2,    1, 3, 1,   0, 0, 0,            0, 0, 0,         32'h1,     0, 7, 1, 32'h3C0};
      vecs[13] = '{1, 0, 0, 7, 1, 32'h2,    1, 3, 1,   1, 7, 32'h55,       1, 1, 0,         32'h2,     3, 7, 1, 32'h3C0};
      vecs[14] = '{1, 3, 6, 0, 0, 0,        0, 4, 1,   1, 6, 32'h99,       1, 1, 32'hABCD,  32'h99,    4, 0, 0, 32'h380};
      vecs[15] = '{1, 6, 5, 0, 0, 0,        0, 5, 1,   0, 0, 0,            1, 1, 32'h99,    32'h1234,  5, 0, 0, 32'h380};
      vecs[16] = '{0, 0, 0, 0, 0, 0,        0, 0, 1,   0, 0, 0,            1, 0, 32'h99,    32'h1234,  5, 0, 0, 32'h380};

      idle = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      rst_n = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", -1, 32'(dec_ready), 32'h1);
      check_ex(-1, idle);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         #1;
         check("dec_ready", i, 32'(dec_ready), vecs[i].e_rdy);
         @(posedge clk);
         #1;
         check_ex(i, vecs[i]);
         @(negedge clk);
      end

      // Reset asserted in the middle of a stall: put an entry in flight, then
      // hold a decode that depends on pending x8.
      drive(idle);
      dec_valid = 1'b1; dec_rs1 = 5'd5; dec_rs2 = 5'd0; dec_rd = 5'd0; dec_we = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_exv", 100, 32'(ex_valid), 32'h1);
      check("pre_rst_a",   100, alu_a,         32'h1234);
      @(negedge clk);
      dec_rs1 = 5'd8; dec_rd = 5'd8; dec_we = 1'b1;
      #1;
      check("stall_ready", 101, 32'(dec_ready), 32'h0);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_exv",   102, 32'(ex_valid),  32'h0);
      check("rst_busy",  102, busy,           32'h0);
      check("rst_a",     102, alu_a,          32'h0);
      check("rst_ready", 102, 32'(dec_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_ready", 103, 32'(dec_ready), 32'h1);
      @(posedge clk);
      #1;
      // Register file was cleared by reset, so x8 now reads 0.
      check("rel_exv",  104, 32'(ex_valid), 32'h1);
      check("rel_a",    104, alu_a,         32'h0);
      check("rel_busy", 104, busy,          32'h100);
      check("rel_rd",   104, 32'(ex_rd),    32'h8);

      // x5 was wiped by reset as well.
      @(negedge clk);
      drive(idle);
      dec_valid = 1'b1; dec_rs1 = 5'd5;
      @(posedge clk);
      #1;
      check("post_rst_x5", 105, alu_a, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
